uart_message_tx: RTL

Parametrised message streamer that feeds the existing `uart` transmitter over its `data`/`dataReady`/`busy` handshake. It sends a compile-time string of `MSG_LEN` bytes, either once per `start` or continuously with a programmable idle gap between repetitions. It supports a graceful `stop` and reports completion. It sits between board-level control (buttons, boot logic) and `uart`, and replaces the single-byte hard-coded sender.

---
 rtl/uart_message_tx_pkg.sv | 10 +
 rtl/uart_message_tx.sv | 116 +++++++++++
 2 files changed

// File: rtl/uart_message_tx_pkg.sv
// uart_message_tx_pkg: state encodings and message byte extraction shared by the message streamer
package uart_message_tx_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_NOT_BUSY, GAP} state_t;
  localparam int MAX_MSG_BYTES = 256;
  localparam int MAX_MSG_BITS = 8 * MAX_MSG_BYTES;
  // Byte k of a len-byte packed string; byte 0 is the leftmost character.
  function automatic logic [7:0] msg_byte(input logic [MAX_MSG_BITS-1:0] msg, input int len, input int k);
    return msg[8*(len-1-k) +: 8];
  endfunction
endpackage

// File: rtl/uart_message_tx.sv
// uart_message_tx: streams a fixed string into uart over the data/dataReady/busy handshake
module uart_message_tx
  import uart_message_tx_pkg::*;
#(
  parameter int MSG_LEN = 13,
  parameter logic [8*MSG_LEN-1:0] MSG = "Hello world!\n",
  parameter bit REPEAT = 1'b0,
  parameter int GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       busy,
  output logic [7:0] data,
  output logic       dataReady,
  output logic       active,
  output logic       done
);
  localparam int IDX_W = MSG_LEN > 1 ? $clog2(MSG_LEN) : 1;
  localparam int GAP_W = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  localparam logic [MAX_MSG_BITS-1:0] MSG_EXT = MAX_MSG_BITS'(MSG);
  localparam logic [7:0] BYTE0 = msg_byte(MSG_EXT, MSG_LEN, 0);
  state_t state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
  logic stop_pending, stop_pending_n;
  logic [7:0] data_n;
  logic ready_n, active_n, done_n;
  logic [7:0] next_byte;
  assign next_byte = msg_byte(MSG_EXT, MSG_LEN, int'(idx) + 1);
  // State and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      gap_cnt <= '0;
      stop_pending <= 1'b0;
      data <= '0;
      dataReady <= 1'b0;
      active <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      gap_cnt <= gap_cnt_n;
      stop_pending <= stop_pending_n;
      data <= data_n;
      dataReady <= ready_n;
      active <= active_n;
      done <= done_n;
    end
  end
  // Next state: launch, handshake each byte, wrap or gap when repeating, finish on stop or end.
  always_comb begin
    state_n = state;
    idx_n = idx;
    gap_cnt_n = gap_cnt;
    data_n = data;
    ready_n = dataReady;
    active_n = active;
    done_n = 1'b0;
    stop_pending_n = stop_pending | (state != IDLE && stop);
    case (state)
      IDLE: if (start) begin
        stop_pending_n = stop;
        data_n = BYTE0;
        ready_n = 1'b1;
        idx_n = '0;
        active_n = 1'b1;
        state_n = WAIT_BUSY;
      end
      WAIT_BUSY: if (busy) begin
        ready_n = 1'b0;
        state_n = WAIT_NOT_BUSY;
      end
      WAIT_NOT_BUSY: if (!busy) begin
        if (stop_pending || (idx == LAST_IDX && !REPEAT)) begin
          done_n = 1'b1;
          active_n = 1'b0;
          stop_pending_n = 1'b0;
          state_n = IDLE;
        end else if (idx != LAST_IDX) begin
          idx_n = idx + 1'b1;
          data_n = next_byte;
          ready_n = 1'b1;
          state_n = WAIT_BUSY;
        end else if (GAP_CYCLES == 0) begin
          idx_n = '0;
          data_n = BYTE0;
          ready_n = 1'b1;
          state_n = WAIT_BUSY;
        end else begin
          idx_n = '0;
          gap_cnt_n = GAP_LOAD;
          state_n = GAP;
        end
      end
      GAP: if (stop || stop_pending) begin
        done_n = 1'b1;
        active_n = 1'b0;
        stop_pending_n = 1'b0;
        state_n = IDLE;
      end else if (gap_cnt == '0) begin
        data_n = BYTE0;
        ready_n = 1'b1;
        state_n = WAIT_BUSY;
      end else begin
        gap_cnt_n = gap_cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
